// File: rtl/dut_check_pkg.sv
// Shared types and defaults for the dut result checker.
package dut_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int OUT_W_DEF = 10;
    localparam int CNT_W_DEF = 16;

    typedef struct packed {
        logic [OUT_W_DEF-1:0] mask;
        logic [OUT_W_DEF-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/dut_check_fifo.sv
// Synchronous FIFO for expected vectors; flush empties it in one cycle.
module dut_check_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    // A full FIFO refuses a push even when the same cycle pops.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == DEPTH[AW:0]);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dut_result_checker.sv
// Compares dut results against queued expected vectors and records stats.
// DUT_RESULT_CHECKER_MASK_EN adds a per-vector don't-care mask input.
module dut_result_checker
    import dut_check_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = 16,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             exp_valid,
    output logic             exp_ready,
`ifdef DUT_RESULT_CHECKER_MASK_EN
    input  logic [OUT_W-1:0] exp_mask,
`endif
    input  logic [OUT_W-1:0] exp_data,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [OUT_W-1:0] res_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [OUT_W-1:0] first_fail_xor
);
    typedef struct packed {
        logic [OUT_W-1:0] mask;
        logic [OUT_W-1:0] data;
    } entry_t;

    state_e           state, state_nx;
    logic [CNT_W-1:0] num_r;
    entry_t           din, head;
    logic [OUT_W-1:0] mask_in, diff;
    logic             full, empty, push, pop, start_ok;

`ifdef DUT_RESULT_CHECKER_MASK_EN
    assign mask_in = exp_mask;
`else
    assign mask_in = '0;
`endif

    assign din       = '{mask: mask_in, data: exp_data};
    assign start_ok  = start && (state != RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign pass      = done && (mismatch_cnt == '0);
    assign exp_ready = busy && !full;
    assign res_ready = busy && !empty && (vec_cnt < num_r);
    assign push      = exp_valid && exp_ready;
    assign pop       = res_valid && res_ready;
    assign diff      = (res_data ^ head.data) & ~head.mask;

    dut_check_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start_ok),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = (num_vectors == '0) ? DONE : RUN;
            RUN:        if (pop && (vec_cnt + CNT_W'(1) == num_r)) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            num_r          <= '0;
            vec_cnt        <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            first_fail_xor <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                num_r          <= num_vectors;
                vec_cnt        <= '0;
                mismatch_cnt   <= '0;
                first_fail_idx <= '0;
                first_fail_xor <= '0;
            end else if (pop) begin
                vec_cnt <= vec_cnt + CNT_W'(1);
                // mismatch_cnt never returns to zero within a run, so it marks "first".
                if (diff != '0) begin
                    if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                    if (mismatch_cnt == '0) begin
                        first_fail_idx <= vec_cnt;
                        first_fail_xor <= diff;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dut_result_checker.sv
// Directed self-checking bench for dut_result_checker.
module tb_dut_result_checker;
    logic        clk = 1'b0;
    logic        rst, start, exp_valid, res_valid;
    logic [15:0] num_vectors;
    logic [9:0]  exp_data, res_data;
`ifdef DUT_RESULT_CHECKER_MASK_EN
    logic [9:0]  exp_mask;
`endif
    logic        exp_ready, res_ready, busy, done, pass;
    logic [15:0] vec_cnt, mismatch_cnt, first_fail_idx;
    logic [9:0]  first_fail_xor;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dut_result_checker dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_vectors    (num_vectors),
        .exp_valid      (exp_valid),
        .exp_ready      (exp_ready),
`ifdef DUT_RESULT_CHECKER_MASK_EN
        .exp_mask       (exp_mask),
`endif
        .exp_data       (exp_data),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .vec_cnt        (vec_cnt),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_xor (first_fail_xor)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        num_vectors = n;
        tick();
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [9:0] d, input logic [9:0] m);
        bit ok = 0;
        exp_valid = 1'b1;
        exp_data  = d;
`ifdef DUT_RESULT_CHECKER_MASK_EN
        exp_mask  = m;
`else
        if (m != 10'h0) $display("note: mask ignored in this build");
`endif
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = exp_ready;
            tick();
        end
        exp_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic send_res(input logic [9:0] d);
        bit ok = 0;
        res_valid = 1'b1;
        res_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = res_ready;
            tick();
        end
        res_valid = 1'b0;
        if (!ok) chk("res_timeout", 0, 1);
    endtask

    function automatic logic [9:0] pat(input int i);
        pat = 10'((i * 37 + 5) & 32'h3FF);
    endfunction

    initial begin
        int pidx, ridx;
        bit pu, po, saw_full;
        rst = 1'b1; start = 1'b0; num_vectors = '0;
        exp_valid = 1'b0; res_valid = 1'b0; exp_data = '0; res_data = '0;
`ifdef DUT_RESULT_CHECKER_MASK_EN
        exp_mask = '0;
`endif
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_exp_ready", exp_ready, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_vec_cnt", vec_cnt, 0);

        // 1: single match
        do_start(16'd1);
        push_exp(10'h2A5, 10'h0);
        send_res(10'h2A5);
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_mism", mismatch_cnt, 0);
        chk("t1_vec", vec_cnt, 1);

        // 2: mismatch recording
        do_start(16'd4);
        for (int i = 0; i < 4; i++) push_exp(10'(i), 10'h0);
        send_res(10'h000); send_res(10'h001); send_res(10'h006); send_res(10'h007);
        chk("t2_mism", mismatch_cnt, 2);
        chk("t2_ffi", first_fail_idx, 2);
        chk("t2_ffx", first_fail_xor, 10'h004);
        chk("t2_pass", pass, 0);
        chk("t2_done", done, 1);

        // 3: backpressure with full FIFO and overlapped push/pop
        do_start(16'd20);
        pidx = 0;
        exp_valid = 1'b1;
        for (int c = 0; c < 40 && pidx < 16; c++) begin
            exp_data = pat(pidx);
            pu = exp_ready;
            tick();
            if (pu) pidx++;
        end
        chk("t3_filled", pidx, 16);
        chk("t3_full_ready", exp_ready, 0);
        exp_data = pat(pidx);
        tick();
        chk("t3_full_hold", exp_ready, 0);
        chk("t3_vec0", vec_cnt, 0);
        ridx = 0;
        saw_full = exp_ready;
        for (int c = 0; c < 200 && ridx < 20; c++) begin
            exp_valid = (pidx < 20);
            exp_data  = pat(pidx);
            res_valid = 1'b1;
            res_data  = pat(ridx);
            pu = exp_valid && exp_ready;
            po = res_ready;
            tick();
            if (pu) pidx++;
            if (po) ridx++;
        end
        exp_valid = 1'b0; res_valid = 1'b0;
        chk("t3_first_overlap_refused", saw_full, 0);
        chk("t3_pushed", pidx, 20);
        chk("t3_vec", vec_cnt, 20);
        chk("t3_mism", mismatch_cnt, 0);
        chk("t3_pass", pass, 1);

        // 4: empty stall
        do_start(16'd1);
        res_valid = 1'b1; res_data = 10'h155;
        tick(); tick(); tick();
        chk("t4_stall_ready", res_ready, 0);
        chk("t4_stall_vec", vec_cnt, 0);
        exp_valid = 1'b1; exp_data = 10'h155;
        tick();
        exp_valid = 1'b0;
        chk("t4_ready_after_push", res_ready, 1);
        chk("t4_vec_before", vec_cnt, 0);
        tick();
        res_valid = 1'b0;
        chk("t4_vec_after", vec_cnt, 1);
        chk("t4_pass", pass, 1);

        // surplus expected vectors are discarded by the next start
        do_start(16'd1);
        push_exp(10'h0AA, 10'h0);
        push_exp(10'h0BB, 10'h0);
        send_res(10'h0AA);
        chk("sur_done", done, 1);
        do_start(16'd1);
        push_exp(10'h0CC, 10'h0);
        send_res(10'h0CC);
        chk("sur_mism", mismatch_cnt, 0);
        chk("sur_pass", pass, 1);

        // 5: zero vectors, restart, ignored start, reset mid-run
        do_start(16'd0);
        chk("t5_zero_done", done, 1);
        chk("t5_zero_pass", pass, 1);
        chk("t5_zero_vec", vec_cnt, 0);
        do_start(16'd2);
        chk("t5_busy", busy, 1);
        chk("t5_cleared", vec_cnt, 0);
        push_exp(10'h100, 10'h0);
        send_res(10'h101);
        chk("t5_mism", mismatch_cnt, 1);
        chk("t5_ffx", first_fail_xor, 10'h001);
        do_start(16'd5);
        chk("t5_ign_busy", busy, 1);
        chk("t5_ign_vec", vec_cnt, 1);
        chk("t5_ign_mism", mismatch_cnt, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_pass", pass, 0);
        chk("t5_rst_exp_ready", exp_ready, 0);
        chk("t5_rst_res_ready", res_ready, 0);
        chk("t5_rst_vec", vec_cnt, 0);
        chk("t5_rst_mism", mismatch_cnt, 0);
        chk("t5_rst_ffi", first_fail_idx, 0);
        chk("t5_rst_ffx", first_fail_xor, 0);

`ifdef DUT_RESULT_CHECKER_MASK_EN
        // 6: masked compare
        do_start(16'd2);
        push_exp(10'h3FF, 10'h00F);
        push_exp(10'h3FF, 10'h000);
        send_res(10'h3F0);
        chk("t6_masked_match", mismatch_cnt, 0);
        send_res(10'h3F0);
        chk("t6_mism", mismatch_cnt, 1);
        chk("t6_ffi", first_fail_idx, 1);
        chk("t6_ffx", first_fail_xor, 10'h00F);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
